mod_add_serial: RTL and testbench
=================================

MOD_ADD_SERIAL -- requirements
Module: mod_add_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 32, bits processed per cycle; WIDTH % DIGIT == 0, DIGIT >= 1; NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a, b, p are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports a, b  input  WIDTH each  addends, unsigned.
REQ-008 SHALL have port p  input  WIDTH  modulus, unsigned.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  (a+b) mod p.
REQ-012 SHALL have port reduced  output  1  result equals a+b-p, i.e. the subtraction was selected.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept operands on a rising edge where in_valid && in_ready; a, b and p are latched internally, the digit counter is cleared, add-carry = 0 and sub-borrow = 0, and the state goes IDLE->CALC.
REQ-015 SHALL ignore later input changes, and in_valid while not in IDLE.
REQ-016 SHALL, in CALC cycle k (k = 0..NDIG-1), compute over digit k (bits k*DIGIT +: DIGIT) with LSB digit first:
  - s_k = a_k + b_k + add-carry; store s_k into the sum register; update add-carry.
  - t_k = s_k - p_k - sub-borrow; store t_k into the difference register; update sub-borrow.
REQ-017 SHALL chain add-carry and sub-borrow only between digits, each as one register bit.
REQ-018 SHALL go CALC->DONE on the edge that completes digit NDIG-1, so out_valid rises exactly NDIG edges after the acceptance edge.
REQ-019 SHALL, at DONE, set reduced = add-carry | ~sub-borrow (full sum >= p) and result = reduced ? difference : sum.
REQ-020 SHALL compute result per REQ-019 for any inputs; correctness of the modular result is guaranteed only for a, b < p; no error flag is required.
REQ-021 SHALL hold result and reduced stable while out_valid && !out_ready, for any number of cycles.
REQ-022 SHALL go DONE->IDLE on an edge where out_ready is high; no new operands are accepted in that same cycle, so the minimum issue interval is NDIG+2 cycles.
REQ-023 SHALL, when DIGIT == WIDTH (NDIG = 1), spend one CALC cycle.
REQ-024 SHALL contain no combinational path from in_valid or out_ready to any output.
REQ-025 SHALL use a digit counter ceil(log2(NDIG+1)) bits wide that does not wrap within an operation.

Reset
REQ-026 SHALL, on any edge with rst_n low, set the state to IDLE, in_ready = 1 after reset, out_valid = 0, result = 0, reduced = 0, and clear carries, counter and internal registers.
REQ-027 SHALL, when reset occurs in CALC or DONE, discard the operation with no out_valid pulse; operands accepted in the first cycle after rst_n rises are processed normally.

Verification (WIDTH=256, DIGIT=32, NDIG=8 unless stated)
REQ-028 Bench SHALL cover: p=2^255-19, a=5, b=7 -> result=12, reduced=0, out_valid 8 edges after acceptance.
REQ-029 Bench SHALL cover: p=2^255-19, a=p-1, b=1 -> result=0, reduced=1; and a=b=p-1 -> result=p-2, reduced=1.
REQ-030 Bench SHALL cover: p=2^256-189, a=b=p-1 (sum overflows 256 bits, add-carry=1) -> result=p-2, reduced=1.
REQ-031 Bench SHALL cover: out_ready held low 5 cycles in DONE -> result/reduced constant, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-032 Bench SHALL cover: rst_n low for 1 cycle at CALC digit 3 -> no out_valid, in_ready=1 and result=0 after the edge; the next operation a=1, b=2, p=11 -> 3, reduced=0.
REQ-033 Bench SHALL cover: WIDTH=DIGIT=8, p=251, a=200, b=100 -> result=49, reduced=1, out_valid 1 edge after acceptance; then randomized back-to-back runs compared against a reference (a+b)%p.

Source files
------------

// File: rtl/mod_add_serial.sv
// Digit-serial modular adder: computes (a+b) mod p by running the sum and the
// sum-minus-modulus in parallel, one DIGIT-wide slice per cycle, LSB first.
module mod_add_serial #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             reduced
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, p_r, sum_r, diff_r;
  logic             add_c, sub_b;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   s_full, t_full;
  logic [WIDTH-1:0] s_ins, t_ins;
  logic             last;

  assign last = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit DIGIT of t_full is the borrow: the (DIGIT+1)-bit difference goes negative.
  always_comb begin
    s_full = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, add_c};
    t_full = {1'b0, s_full[DIGIT-1:0]} - {1'b0, p_r[DIGIT-1:0]} - {{DIGIT{1'b0}}, sub_b};
    s_ins  = '0;
    t_ins  = '0;
    s_ins[WIDTH-1 -: DIGIT] = s_full[DIGIT-1:0];
    t_ins[WIDTH-1 -: DIGIT] = t_full[DIGIT-1:0];
  end

  // Operands shift down and results shift in from the top, so after NDIG
  // digits every slice sits at its own position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      p_r    <= '0;
      sum_r  <= '0;
      diff_r <= '0;
      add_c  <= 1'b0;
      sub_b  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            p_r   <= p;
            cnt   <= '0;
            add_c <= 1'b0;
            sub_b <= 1'b0;
          end
        end
        CALC: begin
          a_r    <= a_r >> DIGIT;
          b_r    <= b_r >> DIGIT;
          p_r    <= p_r >> DIGIT;
          sum_r  <= (sum_r >> DIGIT) | s_ins;
          diff_r <= (diff_r >> DIGIT) | t_ins;
          add_c  <= s_full[DIGIT];
          sub_b  <= t_full[DIGIT];
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Full sum >= p when it overflowed WIDTH bits or the subtraction did not borrow.
  assign reduced = (state == DONE) && (add_c || !sub_b);
  assign result  = reduced ? diff_r : sum_r;

endmodule

// File: tb/tb_mod_add_serial.sv
// Self-checking bench for mod_add_serial: a 256/32 instance and an 8/8 instance,
// directed corner cases plus randomized runs against an arithmetic reference.
module tb_mod_add_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         iv_a, ir_a, ov_a, or_a, rd_a;
  logic [255:0] a_a, b_a, p_a, res_a;
  logic         iv_b, ir_b, ov_b, or_b, rd_b;
  logic [7:0]   a_b, b_b, p_b, res_b;

  int checks   = 0;
  int failures = 0;

  mod_add_serial #(.WIDTH(256), .DIGIT(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
    .a(a_a), .b(b_a), .p(p_a), .out_valid(ov_a), .out_ready(or_a),
    .result(res_a), .reduced(rd_a));

  mod_add_serial #(.WIDTH(8), .DIGIT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
    .a(a_b), .b(b_b), .p(p_b), .out_valid(ov_b), .out_ready(or_b),
    .result(res_b), .reduced(rd_b));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: reduced means the true (unbounded) sum is at least p.
  function automatic logic [256:0] ref_add(input logic [255:0] x, y, m);
    logic [256:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) return {1'b1, 256'(s - {1'b0, m})};
    return {1'b0, s[255:0]};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic get_ready(input bit sel);
    return sel ? ir_b : ir_a;
  endfunction
  function automatic logic get_valid(input bit sel);
    return sel ? ov_b : ov_a;
  endfunction
  function automatic logic get_red(input bit sel);
    return sel ? rd_b : rd_a;
  endfunction
  function automatic logic [255:0] get_res(input bit sel);
    return sel ? {248'b0, res_b} : res_a;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [255:0] x, y, m);
    if (sel) begin iv_b = v; a_b = x[7:0]; b_b = y[7:0]; p_b = m[7:0]; end
    else     begin iv_a = v; a_a = x;      b_a = y;      p_a = m;      end
  endtask

  task automatic set_out_ready(input bit sel, input logic v);
    if (sel) or_b = v; else or_a = v;
  endtask

  task automatic op(input bit sel, input logic [255:0] x, y, m,
                    input logic [255:0] exp_res, input logic exp_red,
                    input int hold, input string tag);
    int n;
    int lat;
    lat = sel ? 1 : 8;
    @(negedge clk);
    chk({tag, ".in_ready"}, 256'(get_ready(sel)), 256'd1);
    drive(sel, 1'b1, x, y, m);
    @(posedge clk); #1;
    drive(sel, 1'b0, rnd256(), rnd256(), rnd256());
    n = 0;
    while (!get_valid(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 256'(n), 256'(lat));
    chk({tag, ".result"}, get_res(sel), exp_res);
    chk({tag, ".reduced"}, 256'(get_red(sel)), 256'(exp_red));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drive(sel, (i % 2) == 0, rnd256(), rnd256(), rnd256());
      @(posedge clk); #1;
      chk({tag, ".hold_result"}, get_res(sel), exp_res);
      chk({tag, ".hold_reduced"}, 256'(get_red(sel)), 256'(exp_red));
      chk({tag, ".hold_in_ready"}, 256'(get_ready(sel)), 256'd0);
      chk({tag, ".hold_out_valid"}, 256'(get_valid(sel)), 256'd1);
    end
    @(negedge clk);
    drive(sel, 1'b0, rnd256(), rnd256(), rnd256());
    set_out_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_out_ready(sel, 1'b0);
    chk({tag, ".release_out_valid"}, 256'(get_valid(sel)), 256'd0);
    chk({tag, ".release_in_ready"}, 256'(get_ready(sel)), 256'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] p25519, p189, x, y, m;
    logic [256:0] r;
    int unsigned  pa, xa, ya;

    p25519 = (256'd1 << 255) - 256'd19;
    p189   = 256'd0 - 256'd189;
    rst_n = 1'b0;
    iv_a = 1'b0; or_a = 1'b0; a_a = '0; b_a = '0; p_a = '0;
    iv_b = 1'b0; or_b = 1'b0; a_b = '0; b_b = '0; p_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a_in_ready", 256'(ir_a), 256'd1);
    chk("rst.a_out_valid", 256'(ov_a), 256'd0);
    chk("rst.a_result", res_a, 256'd0);
    chk("rst.a_reduced", 256'(rd_a), 256'd0);
    chk("rst.b_in_ready", 256'(ir_b), 256'd1);
    chk("rst.b_result", 256'(res_b), 256'd0);
    chk("rst.b_reduced", 256'(rd_b), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(1'b0, 256'd5, 256'd7, p25519, 256'd12, 1'b0, 0, "small");
    op(1'b0, p25519 - 256'd1, 256'd1, p25519, 256'd0, 1'b1, 0, "wrap_zero");
    op(1'b0, p25519 - 256'd1, p25519 - 256'd1, p25519, p25519 - 256'd2, 1'b1, 0, "max25519");
    op(1'b0, p189 - 256'd1, p189 - 256'd1, p189, p189 - 256'd2, 1'b1, 0, "carry_out");
    op(1'b0, 256'd5, 256'd7, p25519, 256'd12, 1'b0, 5, "backpressure");

    // Reset while digit 3 is in flight.
    @(negedge clk);
    drive(1'b0, 1'b1, 256'd9, 256'd9, 256'd13);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.in_ready", 256'(ir_a), 256'd1);
    chk("midrst.out_valid", 256'(ov_a), 256'd0);
    chk("midrst.result", res_a, 256'd0);
    chk("midrst.reduced", 256'(rd_a), 256'd0);
    rst_n = 1'b1;
    op(1'b0, 256'd1, 256'd2, 256'd11, 256'd3, 1'b0, 0, "after_rst");

    op(1'b1, 256'd200, 256'd100, 256'd251, 256'd49, 1'b1, 0, "w8_dir");
    op(1'b1, 256'd200, 256'd100, 256'd251, 256'd49, 1'b1, 3, "w8_hold");

    for (int i = 0; i < 40; i++) begin
      pa = $urandom_range(255, 1);
      xa = $urandom_range(pa - 1, 0);
      ya = $urandom_range(pa - 1, 0);
      op(1'b1, 256'(xa), 256'(ya), 256'(pa), 256'((xa + ya) % pa),
         (xa + ya) >= pa, 0, "w8_rand");
    end

    for (int i = 0; i < 15; i++) begin
      m = rnd256();
      if (i % 3 == 0) m[255] = 1'b1;
      x = rnd256();
      y = rnd256();
      if (i % 2 == 0) begin
        x = x % m;
        y = y % m;
      end
      r = ref_add(x, y, m);
      op(1'b0, x, y, m, r[255:0], r[256], 0, "w256_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
